alram_rd_streamer: RTL

- Read-side master for the alram112x-style dual-port RAM.
- On a start command it issues sequential read addresses to the RAM read port and absorbs the RAM's 2-cycle registered read latency.
- Returned words are delivered as a valid/ready stream with full backpressure, for example coefficient blocks handed to the NTT/compress datapath.
- Buffering is credit-based, so no word is ever lost or duplicated.

---
 rtl/alram_rd_streamer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/alram_rd_streamer.sv
// Sequential read master for a dual-port RAM with a 2-cycle registered read.
// Returned words leave through a credit-protected FIFO as a valid/ready stream.
module alram_rd_streamer #(
  parameter int WID  = 256,
  parameter int AWID = 5,
  parameter int DEP  = 1 << AWID,
  parameter int LWID = AWID + 1,
  parameter int FDEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AWID-1:0] base,
  input  logic [LWID-1:0] len,
  output logic            busy,
  output logic            done,
  output logic [AWID-1:0] ra,
  input  logic [WID-1:0]  rdo,
  output logic [WID-1:0]  odat,
  output logic            ovld,
  output logic            olast,
  input  logic            ordy
);
  localparam int PW = (FDEP > 1) ? $clog2(FDEP) : 1;
  localparam int CW = $clog2(FDEP + 1);
  localparam int UW = CW + 1;
  localparam int EW = WID + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [AWID-1:0] ra_q, ra_d;
  logic [LWID-1:0] rem_q, rem_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      pv_q, pv_d;
  logic [1:0]      pl_q, pl_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [FDEP*EW-1:0] ent_flat;
  logic [EW-1:0]      head;
  logic [UW-1:0]      used;
  logic               issue;
  logic               push;
  logic               pop;
  logic               head_last;

  // Buffered words plus reads still in the RAM pipe must leave room for one more.
  assign used      = UW'(cnt_q) + UW'(pv_q[0]) + UW'(pv_q[1]);
  assign issue     = (state_q == S_RUN) && (rem_q != '0) && (used < UW'(FDEP));
  assign push      = pv_q[1];
  assign ovld      = (cnt_q != '0);
  assign pop       = ovld && ordy;
  assign head      = ent_flat[rd_ptr_q*EW +: EW];
  assign head_last = head[WID];
  assign odat      = ovld ? head[WID-1:0] : '0;
  assign olast     = ovld && head_last;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ra        = ra_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FDEP - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [AWID-1:0] addr_inc(input logic [AWID-1:0] a);
    return (a == AWID'(DEP - 1)) ? '0 : a + AWID'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rem_d   = rem_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len != '0) begin
            ra_d    = base;
            rem_d   = len;
            busy_d  = 1'b1;
            state_d = S_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          ra_d  = addr_inc(ra_q);
          rem_d = rem_q - LWID'(1);
          if (rem_q == LWID'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && head_last) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The last-word tag travels alongside each read through the latency pipe.
  always_comb begin
    pv_d     = {pv_q[0], issue};
    pl_d     = {pl_q[0], issue && (rem_q == LWID'(1))};
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  for (genvar gi = 0; gi < FDEP; gi++) begin : g_ent
    logic [EW-1:0] ent_q, ent_d;
    always_comb begin
      ent_d = ent_q;
      if (push && (wr_ptr_q == PW'(gi))) ent_d = {pl_q[1], rdo};
    end
    always_ff @(posedge clk) ent_q <= ent_d;
    assign ent_flat[gi*EW +: EW] = ent_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      ra_q     <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pv_q     <= '0;
      pl_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ra_q     <= ra_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pv_q     <= pv_d;
      pl_q     <= pl_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule
